// File: rtl/remote_comm.sv
// remote_comm: UART command link; sends a 16-bit command as two 8N1 bytes (high byte first) and receives 8N1 response bytes.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   send_cmd     request to transmit cmd (accepted only when TX is idle)
//   cmd[15:0]    command captured on an accepted send_cmd
//   cmd_snt      high once both command bytes have left TX
//   TX           registered UART serial out, 8N1
//   RX           asynchronous UART serial in, 8N1
//   resp[7:0]    last received response byte
//   resp_rdy     resp holds an unread byte
//   clr_resp_rdy clears resp_rdy
// Optional feature: define REMOTE_COMM_FRAME_CHK_EN to discard received frames whose stop bit samples 0.
module remote_comm #(
    parameter int BAUD_DIV = 5208
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_cmd,
    input  logic [15:0] cmd,
    output logic        cmd_snt,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    input  logic        clr_resp_rdy
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] TX_HIGH = 2'd1;
    localparam logic [1:0] TX_LOW  = 2'd2;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;
    localparam logic [15:0] BIT_END  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_END = 16'(BAUD_DIV / 2 - 1);

    logic [1:0]  tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [15:0] cmd_q, cmd_d;
    logic        tx_q, tx_d;
    logic        cmd_snt_q, cmd_snt_d;
    logic [7:0]  tx_byte;
    logic        send_acc, tx_bit_end, tx_last;

    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]  rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  resp_q, resp_d;
    logic        resp_rdy_q, resp_rdy_d;
    logic        rx_fall, rx_bit_end, rx_half_end, rx_stop_smp, rx_acc;

    assign send_acc   = (tx_state_q == IDLE) && send_cmd;
    assign tx_bit_end = tx_cnt_q == BIT_END;
    // bit index 0 is the start bit, 1..8 data, 9 the stop bit
    assign tx_last    = tx_bit_end && (tx_bit_q == 4'd9);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        cmd_d      = cmd_q;
        cmd_snt_d  = cmd_snt_q;
        if (tx_state_q == IDLE) begin
            tx_cnt_d = '0;
            tx_bit_d = '0;
            if (send_cmd) begin
                tx_state_d = TX_HIGH;
                cmd_d      = cmd;
                cmd_snt_d  = 1'b0;
            end
        end else if (tx_bit_end) begin
            tx_cnt_d = '0;
            tx_bit_d = tx_last ? 4'd0 : tx_bit_q + 4'd1;
            if (tx_last) begin
                tx_state_d = (tx_state_q == TX_HIGH) ? TX_LOW : IDLE;
                cmd_snt_d  = tx_state_q == TX_LOW;
            end
        end
    end

    // TX is computed from the next state so the registered line changes together with the FSM
    assign tx_byte = (tx_state_d == TX_LOW) ? cmd_d[7:0] : cmd_d[15:8];
    assign tx_d    = (tx_state_d == IDLE) ? 1'b1 :
                     (tx_bit_d == 4'd0) ? 1'b0 :
                     (tx_bit_d == 4'd9) ? 1'b1 : tx_byte[3'(tx_bit_d - 4'd1)];

    assign rx_fall     = rx_prev_q && !rx_s2_q;
    assign rx_bit_end  = rx_cnt_q == BIT_END;
    assign rx_half_end = rx_cnt_q == HALF_END;
    assign rx_stop_smp = (rx_state_q == R_STOP) && rx_bit_end;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        if (rx_state_q == R_IDLE) begin
            rx_cnt_d = '0;
            if (rx_fall) rx_state_d = R_START;
        end else if (rx_state_q == R_START) begin
            if (rx_half_end) begin
                rx_cnt_d   = '0;
                rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
            end
        end else if (rx_bit_end) begin
            rx_cnt_d = '0;
            if (rx_state_q == R_DATA) begin
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
            end else begin
                rx_state_d = R_IDLE;
            end
        end
    end

`ifdef REMOTE_COMM_FRAME_CHK_EN
    assign rx_acc = rx_stop_smp && rx_s2_q;
`else
    assign rx_acc = rx_stop_smp;
`endif

    // a byte-accept outranks both clear sources
    assign resp_d     = rx_acc ? rx_sh_q : resp_q;
    assign resp_rdy_d = rx_acc || (resp_rdy_q && !send_acc && !clr_resp_rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            cmd_q      <= '0;
            tx_q       <= 1'b1;
            cmd_snt_q  <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            cmd_q      <= cmd_d;
            tx_q       <= tx_d;
            cmd_snt_q  <= cmd_snt_d;
            rx_s1_q    <= RX;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
        end
    end

    assign TX       = tx_q;
    assign cmd_snt  = cmd_snt_q;
    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: self-checking bench for remote_comm with BAUD_DIV=16.
module tb_remote_comm;
    localparam int BD = 16;
`ifdef REMOTE_COMM_FRAME_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        send_cmd = 1'b0;
    logic [15:0] cmd = '0;
    logic        cmd_snt;
    logic        TX;
    logic        RX = 1'b1;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        clr_resp_rdy = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] m_resp;
    logic       m_rdy;

    remote_comm #(.BAUD_DIV(BD)) dut (
        .clk(clk), .rst(rst), .send_cmd(send_cmd), .cmd(cmd), .cmd_snt(cmd_snt),
        .TX(TX), .RX(RX), .resp(resp), .resp_rdy(resp_rdy), .clr_resp_rdy(clr_resp_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic [7:0] e_resp;
        logic       e_rdy;
    } rx_vec_t;

    rx_vec_t tbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line-level frame of a command: bit k of this word is TX during the k-th bit period.
    function automatic logic [19:0] tx_frame(input logic [15:0] c);
        return {1'b1, c[7:0], 1'b0, 1'b1, c[15:8], 1'b0};
    endfunction

    // One concurrent TX/RX episode; iteration t drives inputs that edge t samples.
    task automatic run(input logic do_tx, input logic [15:0] c, input int send_t, input int re_k,
                       input logic [15:0] re_c, input logic do_rx, input logic [7:0] b,
                       input logic stop, input int clr_t);
        logic [19:0] tf;
        logic [9:0]  rf;
        int n;
        int k;
        tf = tx_frame(c);
        rf = {stop, b, 1'b0};
        n = do_tx ? send_t + 322 : 160;
        if (n < 160) n = 160;
        for (int t = 0; t < n; t++) begin
            k = t - 1 - send_t;
            if (do_tx && k >= 0 && k < 20 * BD) begin
                chk("tx_bit", TX, tf[k / BD]);
                chk("cmd_snt_busy", cmd_snt, 0);
            end
            if (do_tx && k == 20 * BD) begin
                chk("cmd_snt_done", cmd_snt, 1);
                chk("tx_idle", TX, 1);
            end
            RX = (do_rx && t < 10 * BD) ? rf[t / BD] : 1'b1;
            send_cmd = do_tx && (t == send_t || (re_k >= 0 && k == re_k));
            cmd = (t == send_t) ? c : re_c;
            clr_resp_rdy = (t == clr_t);
            tick();
        end
        RX = 1'b1;
        send_cmd = 1'b0;
        clr_resp_rdy = 1'b0;
        repeat (4) tick();
    endtask

    task automatic clear_rdy();
        clr_resp_rdy = 1'b1;
        tick();
        clr_resp_rdy = 1'b0;
        m_rdy = 1'b0;
        chk("clr_rdy", resp_rdy, 0);
    endtask

    initial begin
        logic [19:0] tf;
        logic        stay;
        tbl[0] = '{8'hC3, 1'b1, 8'hC3, 1'b1};
        tbl[1] = '{8'h3C, 1'b0, CHK ? 8'hC3 : 8'h3C, !CHK};
        tbl[2] = '{8'h00, 1'b1, 8'h00, 1'b1};
        tbl[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[4] = '{8'h5A, 1'b0, CHK ? 8'hFF : 8'h5A, !CHK};

        repeat (3) tick();
        chk("rst_tx", TX, 1);
        chk("rst_cmd_snt", cmd_snt, 0);
        chk("rst_resp", resp, 0);
        chk("rst_resp_rdy", resp_rdy, 0);
        rst = 1'b0;
        tick();
        m_resp = 8'h00;
        m_rdy = 1'b0;

        for (int i = 0; i < 5; i++) begin
            clear_rdy();
            run(1'b0, 16'h0, 0, -1, 16'h0, 1'b1, tbl[i].b, tbl[i].stop, -1);
            chk("tbl_resp", resp, tbl[i].e_resp);
            chk("tbl_rdy", resp_rdy, tbl[i].e_rdy);
        end
        m_resp = tbl[4].e_resp;
        m_rdy = tbl[4].e_rdy;

        run(1'b1, 16'hA55A, 0, -1, 16'h0, 1'b0, 8'h0, 1'b1, -1);
        run(1'b1, 16'hA55A, 0, 100, 16'hFFFF, 1'b0, 8'h0, 1'b1, -1);
        m_rdy = 1'b0;

        clear_rdy();
        RX = 1'b0;
        repeat (4) tick();
        RX = 1'b1;
        repeat (40) tick();
        chk("glitch_rdy", resp_rdy, 0);
        chk("glitch_resp", resp, m_resp);
        run(1'b0, 16'h0, 0, -1, 16'h0, 1'b1, 8'h81, 1'b1, -1);
        chk("post_glitch_resp", resp, 8'h81);
        chk("post_glitch_rdy", resp_rdy, 1);

        clear_rdy();
        run(1'b0, 16'h0, 0, -1, 16'h0, 1'b1, 8'h96, 1'b1, 154);
        chk("set_vs_clr_rdy", resp_rdy, 1);
        chk("set_vs_clr_resp", resp, 8'h96);
        run(1'b1, 16'h5AA5, 154, -1, 16'h0, 1'b1, 8'h69, 1'b1, -1);
        chk("set_vs_send_rdy", resp_rdy, 1);
        chk("set_vs_send_resp", resp, 8'h69);

        tf = tx_frame(16'h1234);
        send_cmd = 1'b1;
        cmd = 16'h1234;
        tick();
        send_cmd = 1'b0;
        for (int k = 0; k < 50; k++) begin
            chk("abort_tx_bit", TX, tf[k / BD]);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_tx", TX, 1);
        chk("abort_cmd_snt", cmd_snt, 0);
        chk("abort_rdy", resp_rdy, 0);
        chk("abort_resp", resp, 0);
        stay = 1'b1;
        for (int k = 0; k < 330; k++) begin
            tick();
            stay = stay & TX & !cmd_snt;
        end
        chk("abort_no_resume", stay, 1);
        run(1'b1, 16'h00FF, 0, -1, 16'h0, 1'b0, 8'h0, 1'b1, -1);
        m_resp = 8'h00;
        m_rdy = 1'b0;

        for (int i = 0; i < 20; i++) begin
            logic        do_tx, stop;
            logic [7:0]  b;
            logic [15:0] c, rc;
            int          st, rk, ct;
            do_tx = 1'($urandom_range(0, 1));
            b = 8'($urandom);
            stop = $urandom_range(0, 3) != 0;
            c = 16'($urandom);
            rc = 16'($urandom);
            st = $urandom_range(0, 20);
            rk = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 318)) : -1;
            ct = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 140)) : -1;
            if (ct >= 0 || do_tx) m_rdy = 1'b0;
            if (stop || !CHK) begin
                m_resp = b;
                m_rdy = 1'b1;
            end
            run(do_tx, c, st, rk, rc, 1'b1, b, stop, ct);
            chk("rnd_resp", resp, m_resp);
            chk("rnd_rdy", resp_rdy, m_rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
